// File: rtl/lenet_pkg.sv
// Constants shared by the LeNet 5x5 window generator and the convolution PE.
package lenet_pkg;
    localparam int PIX_W     = 8;
    localparam int K         = 5;
    localparam int IMG_W_DEF = 32;
    localparam int IMG_H_DEF = 32;
    localparam int TAP_W     = (K - 1) * PIX_W;
    localparam int WIN_W     = K * K * PIX_W;

    typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/conv_line_buffer.sv
// Column-indexed line store: one word per image column holding the four previous rows.
// Registered write, combinational read, so a read-modify-write at one address fits in one cycle.
module conv_line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Old contents are returned while the same address is being overwritten.
    assign rdata = mem[addr];
endmodule

// File: rtl/conv_window_5x5.sv
// Streaming 5x5 window generator: raster pixels in, one full window per valid output position out.
// Window bytes are row-major; byte 0 is the top-left pixel, byte 24 the newest pixel.
module conv_window_5x5
    import lenet_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             soft_clr,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pix,
    output logic             win_valid,
    output logic [WIN_W-1:0] win_out,
    output logic [4:0]       out_row,
    output logic [4:0]       out_col,
    output logic             frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]    col_reg;
    logic [RW-1:0]    row_reg;
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             win_fire;
    logic [TAP_W-1:0] tap_rd;
    logic [TAP_W-1:0] tap_wr;
    logic [WIN_W-1:0] win_flat;

    pix_t col_new  [K];
    pix_t win_reg  [K][K];
    pix_t win_next [K][K];

    // A frame abort outranks a pixel arriving in the same cycle.
    assign accept   = in_valid && !soft_clr;
    assign col_last = (col_reg == CW'(IMG_W - 1));
    assign row_last = (row_reg == RW'(IMG_H - 1));
    assign win_fire = accept && (row_reg >= RW'(K - 1)) && (col_reg >= CW'(K - 1));
    assign tap_wr   = {tap_rd[TAP_W-PIX_W-1:0], in_pix};

    conv_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (TAP_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (accept),
        .addr  (col_reg),
        .wdata (tap_wr),
        .rdata (tap_rd)
    );

    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            // Oldest tap byte sits in the top bits and feeds the top window row.
            if (gi < K - 1) begin : g_tap
                assign col_new[gi] = tap_rd[(K-2-gi)*PIX_W +: PIX_W];
            end else begin : g_pix
                assign col_new[gi] = in_pix;
            end

            for (gj = 0; gj < K; gj++) begin : g_col
                if (gj < K - 1) begin : g_shift
                    assign win_next[gi][gj] = win_reg[gi][gj+1];
                end else begin : g_load
                    assign win_next[gi][gj] = col_new[gi];
                end

                assign win_flat[(gi*K+gj)*PIX_W +: PIX_W] = win_next[gi][gj];

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        win_reg[gi][gj] <= '0;
                    end else if (accept) begin
                        win_reg[gi][gj] <= win_next[gi][gj];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_reg    <= '0;
            row_reg    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_out    <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            win_valid  <= win_fire;
            frame_done <= accept && col_last && row_last;
            if (soft_clr) begin
                col_reg <= '0;
                row_reg <= '0;
            end else if (in_valid) begin
                if (col_last) begin
                    col_reg <= '0;
                    row_reg <= row_last ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
            // Output registers only move when a real window is presented.
            if (win_fire) begin
                win_out <= win_flat;
                out_row <= 5'(row_reg - RW'(K - 1));
                out_col <= 5'(col_reg - CW'(K - 1));
            end
        end
    end
endmodule

// File: tb/tb_conv_window_5x5.sv
// Bench for conv_window_5x5: random-gap raster streams checked against a whole-frame image model.
module tb_conv_window_5x5;
    localparam int IMG_W = 32;
    localparam int IMG_H = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         soft_clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_pix = 8'h00;
    logic         win_valid;
    logic [199:0] win_out;
    logic [4:0]   out_row;
    logic [4:0]   out_col;
    logic         frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: position in the current frame and every pixel received so far.
    int           mr = 0;
    int           mc = 0;
    logic [7:0]   img [IMG_H][IMG_W];
    logic         exp_valid = 1'b0;
    logic         exp_done = 1'b0;
    logic [199:0] exp_win = '0;
    logic [4:0]   exp_row = '0;
    logic [4:0]   exp_col = '0;

    always #5 clk = ~clk;

    conv_window_5x5 #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .soft_clr   (soft_clr),
        .in_valid   (in_valid),
        .in_pix     (in_pix),
        .win_valid  (win_valid),
        .win_out    (win_out),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    function automatic logic [7:0] ramp(input int r, input int c);
        return 8'((32 * r + c) % 256);
    endfunction

    // Drive one cycle, then advance the model; the window is the 5x5 patch of the stored image.
    task automatic step(input logic v, input logic [7:0] p, input logic clr);
        in_valid = v;
        in_pix   = p;
        soft_clr = clr;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (clr) begin
            mr = 0;
            mc = 0;
        end else if (v) begin
            img[mr][mc] = p;
            if (mr >= 4 && mc >= 4) begin
                exp_valid = 1'b1;
                exp_row   = 5'(mr - 4);
                exp_col   = 5'(mc - 4);
                for (int k = 0; k < 25; k++) begin
                    exp_win[8*k +: 8] = img[mr - 4 + k / 5][mc - 4 + k % 5];
                end
            end
            exp_done = (mr == IMG_H - 1) && (mc == IMG_W - 1);
            if (mc == IMG_W - 1) begin
                mc = 0;
                mr = (mr == IMG_H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'(i % 2);
            in_pix   = 8'($urandom);
            @(posedge clk);
            #1;
            checks += 5;
            if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %b exp 0", win_valid); end
            if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
            if (win_out !== 200'd0) begin errors++; $display("FAIL reset_win_out got %h exp 0", win_out); end
            if (out_row !== 5'd0) begin errors++; $display("FAIL reset_out_row got %0d exp 0", out_row); end
            if (out_col !== 5'd0) begin errors++; $display("FAIL reset_out_col got %0d exp 0", out_col); end
        end
        in_valid = 1'b0;
        #3 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'($urandom), 1'b0);
            checks += 2;
            if (win_valid !== exp_valid) begin errors++; $display("FAIL idle_win_valid got %b exp %b", win_valid, exp_valid); end
            if (win_out !== exp_win) begin errors++; $display("FAIL idle_win_out got %h exp %h", win_out, exp_win); end
        end
    endtask

    task automatic test_ramp();
        int nwin = 0;
        int ndone = 0;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, ramp(mr, mc), 1'b0);
            checks += 5;
            if (win_valid !== exp_valid) begin errors++; $display("FAIL ramp_win_valid px %0d got %b exp %b", i, win_valid, exp_valid); end
            if (frame_done !== exp_done) begin errors++; $display("FAIL ramp_frame_done px %0d got %b exp %b", i, frame_done, exp_done); end
            if (win_out !== exp_win) begin errors++; $display("FAIL ramp_win_out px %0d got %h exp %h", i, win_out, exp_win); end
            if (out_row !== exp_row) begin errors++; $display("FAIL ramp_out_row px %0d got %0d exp %0d", i, out_row, exp_row); end
            if (out_col !== exp_col) begin errors++; $display("FAIL ramp_out_col px %0d got %0d exp %0d", i, out_col, exp_col); end
            if (win_valid === 1'b1) begin
                nwin++;
                if (nwin == 1) begin
                    checks += 4;
                    if (i != 4 * 32 + 4) begin errors++; $display("FAIL ramp_first_pos got px %0d exp 132", i); end
                    if (win_out[7:0] !== 8'd0) begin errors++; $display("FAIL ramp_first_b0 got %0d exp 0", win_out[7:0]); end
                    if (win_out[103:96] !== 8'd66) begin errors++; $display("FAIL ramp_first_b12 got %0d exp 66", win_out[103:96]); end
                    if (win_out[199:192] !== 8'd132 || out_row !== 5'd0 || out_col !== 5'd0) begin
                        errors++;
                        $display("FAIL ramp_first_b24 got %0d r %0d c %0d exp 132 r 0 c 0", win_out[199:192], out_row, out_col);
                    end
                end
            end
            if (frame_done === 1'b1) begin
                ndone++;
                checks++;
                if (out_row !== 5'd27 || out_col !== 5'd27 || win_out[199:192] !== 8'd255) begin
                    errors++;
                    $display("FAIL ramp_last got r %0d c %0d b24 %0d exp r 27 c 27 b24 255", out_row, out_col, win_out[199:192]);
                end
            end
        end
        checks += 2;
        if (nwin != 784) begin errors++; $display("FAIL ramp_count got %0d exp 784", nwin); end
        if (ndone != 1) begin errors++; $display("FAIL ramp_done_count got %0d exp 1", ndone); end
    endtask

    task automatic test_gaps();
        int nwin = 0;
        int acc = 0;
        int cyc = 0;
        logic v;
        while (acc < 1024 && cyc < 6000) begin
            v = 1'($urandom_range(0, 1));
            step(v, v ? ramp(mr, mc) : 8'($urandom), 1'b0);
            if (v) acc++;
            cyc++;
            checks += 6;
            if (win_valid !== exp_valid) begin errors++; $display("FAIL gaps_win_valid cyc %0d got %b exp %b", cyc, win_valid, exp_valid); end
            if (frame_done !== exp_done) begin errors++; $display("FAIL gaps_frame_done cyc %0d got %b exp %b", cyc, frame_done, exp_done); end
            if (win_out !== exp_win) begin errors++; $display("FAIL gaps_win_out cyc %0d got %h exp %h", cyc, win_out, exp_win); end
            if (out_row !== exp_row) begin errors++; $display("FAIL gaps_out_row cyc %0d got %0d exp %0d", cyc, out_row, exp_row); end
            if (out_col !== exp_col) begin errors++; $display("FAIL gaps_out_col cyc %0d got %0d exp %0d", cyc, out_col, exp_col); end
            if (!v && win_valid !== 1'b0) begin errors++; $display("FAIL gaps_idle_valid cyc %0d got %b exp 0", cyc, win_valid); end
            if (win_valid === 1'b1) nwin++;
        end
        checks += 2;
        if (acc != 1024) begin errors++; $display("FAIL gaps_budget got %0d pixels exp 1024", acc); end
        if (nwin != 784) begin errors++; $display("FAIL gaps_count got %0d exp 784", nwin); end
    endtask

    task automatic test_back_to_back();
        int nwin = 0;
        int ndone = 0;
        logic [199:0] all11;
        all11 = {25{8'h11}};
        for (int i = 0; i < 2048; i++) begin
            step(1'b1, (i < 1024) ? ramp(mr, mc) : 8'h11, 1'b0);
            checks += 5;
            if (win_valid !== exp_valid) begin errors++; $display("FAIL b2b_win_valid px %0d got %b exp %b", i, win_valid, exp_valid); end
            if (frame_done !== exp_done) begin errors++; $display("FAIL b2b_frame_done px %0d got %b exp %b", i, frame_done, exp_done); end
            if (win_out !== exp_win) begin errors++; $display("FAIL b2b_win_out px %0d got %h exp %h", i, win_out, exp_win); end
            if (out_row !== exp_row) begin errors++; $display("FAIL b2b_out_row px %0d got %0d exp %0d", i, out_row, exp_row); end
            if (out_col !== exp_col) begin errors++; $display("FAIL b2b_out_col px %0d got %0d exp %0d", i, out_col, exp_col); end
            if (win_valid === 1'b1) nwin++;
            if (frame_done === 1'b1) ndone++;
            if (i >= 1024 && win_valid === 1'b1) begin
                checks++;
                if (win_out !== all11) begin errors++; $display("FAIL b2b_const px %0d got %h exp all 11", i, win_out); end
            end
        end
        checks += 2;
        if (nwin != 1568) begin errors++; $display("FAIL b2b_count got %0d exp 1568", nwin); end
        if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", ndone); end
    endtask

    task automatic test_soft_clr();
        int nwin = 0;
        for (int i = 0; i < 1024 + 10 * 32 + 8; i++) begin
            // Pixel index 327 is (10,7) of the aborted frame; it arrives with soft_clr.
            step(1'b1, ramp(mr, mc), 1'(i == 10 * 32 + 7));
            checks += 5;
            if (win_valid !== exp_valid) begin errors++; $display("FAIL clr_win_valid px %0d got %b exp %b", i, win_valid, exp_valid); end
            if (frame_done !== exp_done) begin errors++; $display("FAIL clr_frame_done px %0d got %b exp %b", i, frame_done, exp_done); end
            if (win_out !== exp_win) begin errors++; $display("FAIL clr_win_out px %0d got %h exp %h", i, win_out, exp_win); end
            if (out_row !== exp_row) begin errors++; $display("FAIL clr_out_row px %0d got %0d exp %0d", i, out_row, exp_row); end
            if (out_col !== exp_col) begin errors++; $display("FAIL clr_out_col px %0d got %0d exp %0d", i, out_col, exp_col); end
            if (i > 10 * 32 + 7 && win_valid === 1'b1) begin
                nwin++;
                if (nwin == 1) begin
                    checks++;
                    if (i != 10 * 32 + 8 + 4 * 32 + 4 || out_row !== 5'd0 || out_col !== 5'd0) begin
                        errors++;
                        $display("FAIL clr_first got px %0d r %0d c %0d exp px 460 r 0 c 0", i, out_row, out_col);
                    end
                end
            end
        end
        checks++;
        if (nwin != 784) begin errors++; $display("FAIL clr_count got %0d exp 784", nwin); end
    endtask

    task automatic test_async_reset();
        int nwin = 0;
        for (int i = 0; i < 10 * 32 + 10; i++) begin
            step(1'b1, ramp(mr, mc), 1'b0);
        end
        checks++;
        if (win_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", win_valid); end
        #2 reset_n = 1'b0;
        #1;
        mr = 0; mc = 0;
        exp_valid = 1'b0; exp_done = 1'b0; exp_win = '0; exp_row = '0; exp_col = '0;
        checks += 3;
        if (win_valid !== 1'b0) begin errors++; $display("FAIL arst_win_valid got %b exp 0", win_valid); end
        if (win_out !== 200'd0) begin errors++; $display("FAIL arst_win_out got %h exp 0", win_out); end
        if (out_row !== 5'd0 || out_col !== 5'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL arst_outputs got r %0d c %0d fd %b exp 0", out_row, out_col, frame_done);
        end
        in_valid = 1'b0;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, ramp(mr, mc), 1'b0);
            checks += 5;
            if (win_valid !== exp_valid) begin errors++; $display("FAIL arst2_win_valid px %0d got %b exp %b", i, win_valid, exp_valid); end
            if (frame_done !== exp_done) begin errors++; $display("FAIL arst2_frame_done px %0d got %b exp %b", i, frame_done, exp_done); end
            if (win_out !== exp_win) begin errors++; $display("FAIL arst2_win_out px %0d got %h exp %h", i, win_out, exp_win); end
            if (out_row !== exp_row) begin errors++; $display("FAIL arst2_out_row px %0d got %0d exp %0d", i, out_row, exp_row); end
            if (out_col !== exp_col) begin errors++; $display("FAIL arst2_out_col px %0d got %0d exp %0d", i, out_col, exp_col); end
            if (win_valid === 1'b1) nwin++;
        end
        checks++;
        if (nwin != 784) begin errors++; $display("FAIL arst2_count got %0d exp 784", nwin); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_back_to_back();
        test_soft_clr();
        test_async_reset();
        step(1'b0, 8'h00, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
